unsigned_shift_add_mult: RTL and testbench



---
 rtl/unsigned_shift_add_mult.sv | 100 ++++++++++
 tb/tb_unsigned_shift_add_mult.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/unsigned_shift_add_mult.sv
// rtl/unsigned_shift_add_mult.sv - sequential unsigned shift-add multiplier, start/busy/done handshake
// Optional early finish on all-zero remaining multiplier bits: define ZERO_SKIP_EN.
module unsigned_shift_add_mult #(
   parameter int DATA_WIDTH = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [DATA_WIDTH-1:0]     multiplicand,
   input  logic [DATA_WIDTH-1:0]     multiplier,
   output logic [2*DATA_WIDTH-1:0]   product,
   output logic                      busy,
   output logic                      done
);
   localparam int CW = $clog2(DATA_WIDTH + 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                state;
   state_t                state_next;
   logic [DATA_WIDTH-1:0] a;
   logic [DATA_WIDTH-1:0] q;
   logic [DATA_WIDTH-1:0] m;
   logic [CW-1:0]         count;
   logic [DATA_WIDTH:0]   sum;
   logic [DATA_WIDTH-1:0] a_shift;
   logic [DATA_WIDTH-1:0] q_shift;
   logic                  last;
   logic                  skip;
   logic                  accept;

   // The carry of the add is sum[DATA_WIDTH]; it lands in A's MSB after the shift.
   assign sum     = q[0] ? ({1'b0, a} + {1'b0, m}) : {1'b0, a};
   assign a_shift = sum[DATA_WIDTH:1];
   assign q_shift = {sum[0], q[DATA_WIDTH-1:1]};
   assign last    = (count == CW'(DATA_WIDTH - 1));
   assign accept  = start && (state == IDLE || state == DONE);
   assign busy    = (state == RUN);
   assign done    = (state == DONE);

`ifdef ZERO_SKIP_EN
   logic [DATA_WIDTH-1:0]   pending_mask;
   logic [CW:0]             skip_shamt;
   logic [2*DATA_WIDTH-1:0] skip_product;

   // Ones over the multiplier bits not yet consumed: bits [DATA_WIDTH-1-count:0].
   assign pending_mask = {DATA_WIDTH{1'b1}} >> count;
   assign skip         = (state == RUN) && ((q & pending_mask) == '0);
   assign skip_shamt   = (CW + 1)'(DATA_WIDTH) - {1'b0, count};
   assign skip_product = {a, q} >> skip_shamt;
`else
   assign skip = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = RUN;
         RUN:     if (skip || last) state_next = DONE;
         DONE:    state_next = start ? RUN : IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a       <= '0;
         q       <= '0;
         m       <= '0;
         count   <= '0;
         product <= '0;
      end else if (accept) begin
         a     <= '0;
         q     <= multiplier;
         m     <= multiplicand;
         count <= '0;
      end else if (state == RUN) begin
`ifdef ZERO_SKIP_EN
         if (skip) begin
            product <= skip_product;
         end else begin
`else
         begin
`endif
            a     <= a_shift;
            q     <= q_shift;
            count <= count + 1'b1;
            if (last) product <= {a_shift, q_shift};
         end
      end
   end
endmodule

// File: tb/tb_unsigned_shift_add_mult.sv
// tb/tb_unsigned_shift_add_mult.sv - table-driven bench for unsigned_shift_add_mult (DATA_WIDTH=4)
// Latency expectations follow ZERO_SKIP_EN when that macro is defined.
module tb_unsigned_shift_add_mult;
   localparam int DW = 4;

`ifdef ZERO_SKIP_EN
   localparam bit SKIP = 1'b1;
`else
   localparam bit SKIP = 1'b0;
`endif

   typedef struct {
      logic [DW-1:0]   m;
      logic [DW-1:0]   q;
      logic [2*DW-1:0] p;
      int              lat_norm;
      int              lat_skip;
   } vec_t;

   logic            clk = 1'b0;
   logic            rst;
   logic            start;
   logic [DW-1:0]   multiplicand;
   logic [DW-1:0]   multiplier;
   logic [2*DW-1:0] product;
   logic            busy;
   logic            done;

   int tests = 0;
   int fails = 0;
   vec_t vecs[10];

   unsigned_shift_add_mult #(.DATA_WIDTH(DW)) dut (
      .clk(clk), .rst(rst), .start(start),
      .multiplicand(multiplicand), .multiplier(multiplier),
      .product(product), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Latency counts edges after the accepting edge until done is visible.
   task automatic wait_done(input string name, output int lat);
      bit overlap = 1'b0;
      lat = 0;
      while (!done && lat < 40) begin
         @(posedge clk); #1;
         lat++;
         if (busy && done) overlap = 1'b1;
      end
      check({name, " done seen"}, 64'(done), 64'd1);
      check({name, " busy/done overlap"}, 64'(overlap), 64'd0);
   endtask

   task automatic launch(input logic [DW-1:0] m, input logic [DW-1:0] q);
      @(negedge clk);
      start = 1'b1; multiplicand = m; multiplier = q;
      @(posedge clk); #1;
      start = 1'b0; multiplicand = 'x; multiplier = 'x;
   endtask

   task automatic run_vec(input string name, input vec_t v);
      int lat;
      launch(v.m, v.q);
      check({name, " busy after start"}, 64'(busy), 64'd1);
      wait_done(name, lat);
      check({name, " latency"}, 64'(lat), 64'(SKIP ? v.lat_skip : v.lat_norm));
      check({name, " product"}, 64'(product), 64'(v.p));
      @(posedge clk); #1;
      check({name, " done one cycle"}, 64'(done), 64'd0);
      check({name, " product held"}, 64'(product), 64'(v.p));
   endtask

   initial begin
      int lat;
      vecs[0] = '{m:4'd15, q:4'd15, p:8'd225, lat_norm:4, lat_skip:4};
      vecs[1] = '{m:4'd7,  q:4'd3,  p:8'd21,  lat_norm:4, lat_skip:3};
      vecs[2] = '{m:4'd9,  q:4'd0,  p:8'd0,   lat_norm:4, lat_skip:1};
      vecs[3] = '{m:4'd0,  q:4'd9,  p:8'd0,   lat_norm:4, lat_skip:4};
      vecs[4] = '{m:4'd1,  q:4'd1,  p:8'd1,   lat_norm:4, lat_skip:2};
      vecs[5] = '{m:4'd8,  q:4'd8,  p:8'd64,  lat_norm:4, lat_skip:4};
      vecs[6] = '{m:4'd15, q:4'd1,  p:8'd15,  lat_norm:4, lat_skip:2};
      vecs[7] = '{m:4'd1,  q:4'd15, p:8'd15,  lat_norm:4, lat_skip:4};
      vecs[8] = '{m:4'd10, q:4'd5,  p:8'd50,  lat_norm:4, lat_skip:4};
      vecs[9] = '{m:4'd12, q:4'd10, p:8'd120, lat_norm:4, lat_skip:4};

      rst = 1'b1; start = 1'b0; multiplicand = '0; multiplier = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset product", 64'(product), 64'd0);
      check("reset busy", 64'(busy), 64'd0);
      check("reset done", 64'(done), 64'd0);
      rst = 1'b0;

      for (int i = 0; i < 10; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

      // Back-to-back: start held through the DONE cycle.
      launch(4'd3, 4'd3);
      wait_done("b2b first", lat);
      check("b2b first product", 64'(product), 64'd9);
      start = 1'b1; multiplicand = 4'd5; multiplier = 4'd6;
      @(posedge clk); #1;
      start = 1'b0;
      check("b2b busy in DONE start", 64'(busy), 64'd1);
      check("b2b product kept", 64'(product), 64'd9);
      wait_done("b2b second", lat);
      check("b2b spacing", 64'(lat + 1), 64'(SKIP ? 5 : DW + 1));
      check("b2b product", 64'(product), 64'd30);
      @(posedge clk); #1;

      // start pulsed mid-RUN with other operands is ignored.
      launch(4'd3, 4'd4);
      @(negedge clk);
      start = 1'b1; multiplicand = 4'd15; multiplier = 4'd15;
      @(negedge clk);
      start = 1'b0;
      #6;
      wait_done("ignore", lat);
      check("ignore latency", 64'(lat + 2), 64'(DW));
      check("ignore product", 64'(product), 64'd12);
      @(posedge clk); #1;
      check("ignore no restart", 64'(busy), 64'd0);
      check("ignore product held", 64'(product), 64'd12);

      // Reset in the second RUN cycle aborts and clears product.
      launch(4'd15, 4'd15);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("abort busy", 64'(busy), 64'd0);
      check("abort done", 64'(done), 64'd0);
      check("abort product", 64'(product), 64'd0);
      repeat (6) begin
         @(posedge clk); #1;
         if (done) check("abort spurious done", 64'(done), 64'd0);
      end
      check("abort product stays", 64'(product), 64'd0);
      run_vec("after abort", '{m:4'd2, q:4'd2, p:8'd4, lat_norm:4, lat_skip:3});

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
